dm_wait_state_responder: RTL

//   Data-memory responder for the multi-cycle CPU's load/store port. Accepts one

---
 rtl/dm_wait_state_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dm_wait_state_responder.sv
// Data-memory responder for a multi-cycle CPU load/store port: one word access at a
// time, completed after a fixed number of wait states, with error reporting.
module dm_wait_state_responder #(
  parameter int MEM_BYTES = 128,
  parameter int RD_LAT    = 2,
  parameter int WR_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] MemAddr,
  input  logic [31:0] MemWriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] MemReadData,
  output logic        MemReady,
  output logic        MemErr,
  output logic        MemBusy
);

  localparam int          AW        = $clog2(MEM_BYTES);
  localparam int          WORDS     = MEM_BYTES / 4;
  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);
  localparam logic [3:0]  RD_LAT_C  = 4'(RD_LAT);
  localparam logic [3:0]  WR_LAT_C  = 4'(WR_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_next;

  logic [AW-3:0] r_idx;
  logic [31:0]   r_wdata;
  logic          r_rd;
  logic          r_wr;
  logic          r_err;

  logic [31:0]   r_mem [WORDS];

  logic          r_ready;
  logic          r_err_out;
  logic          r_busy;
  logic [31:0]   r_rdata;

  logic          w_req;
  logic          w_accept;
  logic          w_req_err;
  logic [3:0]    w_lat;
  logic [AW-3:0] w_idx;
  logic [31:0]   w_wdata;
  logic          w_rd;
  logic          w_wr;
  logic          w_err;
  logic          w_enter_done;
  logic          w_do_write;
  logic          w_do_read;
  logic          w_err_read;
  logic [31:0]   w_rd_word;

  assign w_req     = MemRead | MemWrite;
  assign w_req_err = (MemAddr[1:0] != 2'b00) || (MemAddr > LAST_ADDR) || (MemRead && MemWrite);
  assign w_lat     = MemRead ? RD_LAT_C : WR_LAT_C;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_accept = 1'b1;
          if (w_lat == 4'd1) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = w_lat - 4'd2;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // A single-cycle access enters DONE on its accept edge, so the live request
  // must be used there instead of the not-yet-loaded latches.
  assign w_idx   = w_accept ? MemAddr[AW-1:2] : r_idx;
  assign w_wdata = w_accept ? MemWriteData    : r_wdata;
  assign w_rd    = w_accept ? MemRead         : r_rd;
  assign w_wr    = w_accept ? MemWrite        : r_wr;
  assign w_err   = w_accept ? w_req_err       : r_err;

  assign w_enter_done = (w_state_next == S_DONE) && (r_state != S_DONE);
  assign w_do_write   = w_enter_done && w_wr && !w_err;
  assign w_do_read    = w_enter_done && w_rd && !w_err;
  assign w_err_read   = w_enter_done && w_rd && w_err;
  assign w_rd_word    = r_mem[w_idx];

  // Storage keeps its contents across reset; rst_n gating prevents a write
  // from landing on an edge that happens while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && w_do_write) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_wdata   <= 32'd0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_err     <= 1'b0;
      r_ready   <= 1'b0;
      r_err_out <= 1'b0;
      r_busy    <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      if (w_accept) begin
        r_idx   <= MemAddr[AW-1:2];
        r_wdata <= MemWriteData;
        r_rd    <= MemRead;
        r_wr    <= MemWrite;
        r_err   <= w_req_err;
      end
      r_ready   <= (w_state_next == S_DONE);
      r_err_out <= (w_state_next == S_DONE) && w_err;
      r_busy    <= (w_state_next != S_IDLE);
      if (w_do_read) begin
        r_rdata <= w_rd_word;
      end else if (w_err_read) begin
        r_rdata <= 32'd0;
      end
    end
  end

  assign MemReadData = r_rdata;
  assign MemReady    = r_ready;
  assign MemErr      = r_err_out;
  assign MemBusy     = r_busy;

endmodule
